// File: rtl/adc0804_sampler_if.sv
// ADC0804 strobe/data bus plus the result bus presented to the LCD text stage.
// master = sampler side, slave = ADC / downstream side.
interface adc0804_sampler_if;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;
  logic       intr_n;
  logic [7:0] adata;
  logic [7:0] sample;
  logic [7:0] avg;
  logic [7:0] dig_int;
  logic [7:0] dig_tenth;
  logic [7:0] dig_hund;
  logic       valid;
  logic       timeout_err;

  modport master (
    output cs_n, wr_n, rd_n,
    output sample, avg, dig_int, dig_tenth, dig_hund, valid, timeout_err,
    input  intr_n, adata
  );

  modport slave (
    input  cs_n, wr_n, rd_n,
    input  sample, avg, dig_int, dig_tenth, dig_hund, valid, timeout_err,
    output intr_n, adata
  );
endinterface

// File: rtl/adc0804_sampler.sv
// ADC0804 acquisition front-end: start/convert/read handshake, block averaging,
// x2 scaling and a sequential double-dabble into ASCII digits for the LCD stage.
module adc0804_sampler #(
  parameter int SETTLE_TICKS  = 10,
  parameter int RD_TICKS      = 2,
  parameter int TIMEOUT_TICKS = 255,
  parameter int AVG_LOG2      = 2
) (
  input  logic              lcd_clk,
  input  logic              rst,
  adc0804_sampler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_READ,
    S_ACC,
    S_CONV,
    S_DONE
  } state_e;

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_TICKS - 1);
  localparam logic [15:0] RD_LAST      = 16'(RD_TICKS - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_TICKS - 1);
  localparam logic [15:0] CONV_LAST    = 16'd8;
  localparam logic [4:0]  AVG_N        = 5'(1 << AVG_LOG2);
  localparam logic [7:0]  ASCII_ZERO   = 8'h30;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] sum_q, sum_d;
  logic [4:0]  count_q, count_d;
  logic [7:0]  sample_q, sample_d;
  logic [7:0]  avg_q, avg_d;
  logic [8:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [7:0]  dig_int_q, dig_int_d;
  logic [7:0]  dig_tenth_q, dig_tenth_d;
  logic [7:0]  dig_hund_q, dig_hund_d;
  logic        valid_q, valid_d;
  logic        timeout_err_q, timeout_err_d;
  logic        cs_n_q, cs_n_d;
  logic        wr_n_q, wr_n_d;
  logic        rd_n_q, rd_n_d;
  logic        intr_meta_q, intr_sync_q;

  logic [11:0] sum_new;
  logic [7:0]  avg_new;
  logic [4:0]  count_new;
  logic [11:0] bcd_adj;
  logic [11:0] bcd_shift;

  // intr_n is driven by the ADC's own oscillator domain; only intr_sync_q is used.
  always_ff @(posedge lcd_clk or negedge rst) begin
    if (!rst) begin
      intr_meta_q <= 1'b1;
      intr_sync_q <= 1'b1;
    end else begin
      intr_meta_q <= bus.intr_n;
      intr_sync_q <= intr_meta_q;
    end
  end

  always_ff @(posedge lcd_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      sum_q         <= '0;
      count_q       <= '0;
      sample_q      <= '0;
      avg_q         <= '0;
      bin_q         <= '0;
      bcd_q         <= '0;
      dig_int_q     <= ASCII_ZERO;
      dig_tenth_q   <= ASCII_ZERO;
      dig_hund_q    <= ASCII_ZERO;
      valid_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      cs_n_q        <= 1'b1;
      wr_n_q        <= 1'b1;
      rd_n_q        <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sum_q         <= sum_d;
      count_q       <= count_d;
      sample_q      <= sample_d;
      avg_q         <= avg_d;
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      dig_int_q     <= dig_int_d;
      dig_tenth_q   <= dig_tenth_d;
      dig_hund_q    <= dig_hund_d;
      valid_q       <= valid_d;
      timeout_err_q <= timeout_err_d;
      cs_n_q        <= cs_n_d;
      wr_n_q        <= wr_n_d;
      rd_n_q        <= rd_n_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves one unassigned (no latch).
    state_d       = state_q;
    cnt_d         = cnt_q;
    sum_d         = sum_q;
    count_d       = count_q;
    sample_d      = sample_q;
    avg_d         = avg_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    dig_int_d     = dig_int_q;
    dig_tenth_d   = dig_tenth_q;
    dig_hund_d    = dig_hund_q;
    valid_d       = 1'b0;
    timeout_err_d = timeout_err_q;

    sum_new   = sum_q + {4'd0, sample_q};
    avg_new   = 8'(sum_new >> AVG_LOG2);
    count_new = count_q + 5'd1;

    // One double-dabble step: add 3 to any digit >= 5, then shift in the next bit.
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = 12'({bcd_adj, bin_q[8]});

    // Strobes decode the current state and land one edge after state entry.
    cs_n_d = !((state_q == S_START) || (state_q == S_READ));
    wr_n_d = (state_q != S_START);
    rd_n_d = (state_q != S_READ);

    case (state_q)
      S_IDLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_START;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (!intr_sync_q) begin
          state_d = S_READ;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d       = S_IDLE;
          cnt_d         = '0;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          sample_d = bus.adata;
          state_d  = S_ACC;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ACC: begin
        timeout_err_d = 1'b0;
        if (count_new == AVG_N) begin
          avg_d   = avg_new;
          sum_d   = '0;
          count_d = '0;
          bin_d   = {avg_new, 1'b0};
          bcd_d   = '0;
          state_d = S_CONV;
        end else begin
          sum_d   = sum_new;
          count_d = count_new;
          state_d = S_IDLE;
        end
        cnt_d = '0;
      end
      S_CONV: begin
        bin_d = {bin_q[7:0], 1'b0};
        bcd_d = bcd_shift;
        if (cnt_q == CONV_LAST) begin
          dig_int_d   = ASCII_ZERO + {4'd0, bcd_shift[11:8]};
          dig_tenth_d = ASCII_ZERO + {4'd0, bcd_shift[7:4]};
          dig_hund_d  = ASCII_ZERO + {4'd0, bcd_shift[3:0]};
          valid_d     = 1'b1;
          state_d     = S_DONE;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.cs_n        = cs_n_q;
  assign bus.wr_n        = wr_n_q;
  assign bus.rd_n        = rd_n_q;
  assign bus.sample      = sample_q;
  assign bus.avg         = avg_q;
  assign bus.dig_int     = dig_int_q;
  assign bus.dig_tenth   = dig_tenth_q;
  assign bus.dig_hund    = dig_hund_q;
  assign bus.valid       = valid_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc0804_sampler.sv
// Bench for adc0804_sampler: one instance per averaging depth (1 and 4 samples),
// each fed by a behavioural ADC0804 and checked against an expected-result queue.
`timescale 1ns/1ps
module tb_adc0804_sampler;
  localparam int SETTLE = 10;
  localparam int RDT    = 2;
  localparam int TMO    = 255;

  typedef struct packed {
    logic [7:0] avg;
    logic [7:0] d_int;
    logic [7:0] d_tenth;
    logic [7:0] d_hund;
  } exp_t;

  logic lcd_clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] dq0[$];
  logic [7:0] dq2[$];
  exp_t       exp0[$];
  exp_t       exp2[$];
  exp_t       e0, e2;
  int         cnt0, cnt2;

  always #5 lcd_clk = ~lcd_clk;

  adc0804_sampler_if a0 ();
  adc0804_sampler_if a2 ();

  adc0804_sampler #(.SETTLE_TICKS(SETTLE), .RD_TICKS(RDT), .TIMEOUT_TICKS(TMO), .AVG_LOG2(0)) u0 (
    .lcd_clk(lcd_clk),
    .rst    (rst),
    .bus    (a0)
  );

  adc0804_sampler #(.SETTLE_TICKS(SETTLE), .RD_TICKS(RDT), .TIMEOUT_TICKS(TMO), .AVG_LOG2(2)) u2 (
    .lcd_clk(lcd_clk),
    .rst    (rst),
    .bus    (a2)
  );

  function automatic exp_t model(input int sum, input int n);
    exp_t r;
    int   a, v;
    a         = sum / n;
    v         = a * 2;
    r.avg     = 8'(a);
    r.d_int   = 8'(48 + v / 100);
    r.d_tenth = 8'(48 + (v / 10) % 10);
    r.d_hund  = 8'(48 + v % 10);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push0(input logic [7:0] v);
    dq0.push_back(v);
    exp0.push_back(model(int'(v), 1));
  endtask

  task automatic tick();
    @(posedge lcd_clk);
    #1;
  endtask

  // ADC models: intr_n falls ~5 cycles after a wr_n pulse, only when a value is queued.
  always @(negedge lcd_clk or negedge rst) begin
    if (!rst) begin
      a0.intr_n = 1'b1;
      a0.adata  = 8'd0;
      cnt0      = 0;
    end else begin
      if (a0.wr_n == 1'b0) cnt0 = 5;
      else if (cnt0 > 0) begin
        cnt0 = cnt0 - 1;
        if (cnt0 == 0 && dq0.size() > 0) begin
          a0.adata  = dq0.pop_front();
          a0.intr_n = 1'b0;
        end
      end
      if (a0.rd_n == 1'b0) a0.intr_n = 1'b1;
    end
  end

  always @(negedge lcd_clk or negedge rst) begin
    if (!rst) begin
      a2.intr_n = 1'b1;
      a2.adata  = 8'd0;
      cnt2      = 0;
    end else begin
      if (a2.wr_n == 1'b0) cnt2 = 5;
      else if (cnt2 > 0) begin
        cnt2 = cnt2 - 1;
        if (cnt2 == 0 && dq2.size() > 0) begin
          a2.adata  = dq2.pop_front();
          a2.intr_n = 1'b0;
        end
      end
      if (a2.rd_n == 1'b0) a2.intr_n = 1'b1;
    end
  end

  // Result monitors: every valid pulse must match the oldest expected entry.
  always @(negedge lcd_clk) begin
    if (rst === 1'b1 && a0.valid === 1'b1) begin
      check("u0 valid expected", exp0.size() > 0, 1);
      if (exp0.size() > 0) begin
        e0 = exp0.pop_front();
        check("u0 avg", a0.avg, e0.avg);
        check("u0 dig_int", a0.dig_int, e0.d_int);
        check("u0 dig_tenth", a0.dig_tenth, e0.d_tenth);
        check("u0 dig_hund", a0.dig_hund, e0.d_hund);
      end
    end
  end

  always @(negedge lcd_clk) begin
    if (rst === 1'b1 && a2.valid === 1'b1) begin
      check("u2 valid expected", exp2.size() > 0, 1);
      if (exp2.size() > 0) begin
        e2 = exp2.pop_front();
        check("u2 avg", a2.avg, e2.avg);
        check("u2 dig_int", a2.dig_int, e2.d_int);
        check("u2 dig_tenth", a2.dig_tenth, e2.d_tenth);
        check("u2 dig_hund", a2.dig_hund, e2.d_hund);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    repeat (3) @(negedge lcd_clk);

    check("reset u0 cs_n", a0.cs_n, 1);
    check("reset u0 wr_n", a0.wr_n, 1);
    check("reset u0 rd_n", a0.rd_n, 1);
    check("reset u0 dig_int", a0.dig_int, 8'h30);
    check("reset u0 dig_tenth", a0.dig_tenth, 8'h30);
    check("reset u0 dig_hund", a0.dig_hund, 8'h30);
    check("reset u0 valid", a0.valid, 0);
    check("reset u0 timeout_err", a0.timeout_err, 0);
    check("reset u0 sample", a0.sample, 0);
    check("reset u2 avg", a2.avg, 0);
    check("reset u2 cs_n", a2.cs_n, 1);

    // AVG_LOG2=0: mid, full scale and zero; AVG_LOG2=2: 10,20,30,41 -> floor(25.25)
    push0(8'd128);
    push0(8'd255);
    push0(8'd0);
    dq2.push_back(8'd10);
    dq2.push_back(8'd20);
    dq2.push_back(8'd30);
    dq2.push_back(8'd41);
    exp2.push_back(model(101, 4));

    @(negedge lcd_clk);
    rst = 1'b1;
    n = 0;
    do begin tick(); n++; end while (a0.wr_n !== 1'b0 && n < 100);
    check("first wr_n delay", n, SETTLE + 1);
    tick();
    check("wr_n pulse width", a0.wr_n, 1);

    n = 0;
    while (a0.sample !== 8'd128 && n < 200) begin tick(); n++; end
    check("u0 first sample", a0.sample, 128);
    n = 0;
    do begin tick(); n++; end while (a0.valid !== 1'b1 && n < 50);
    check("u0 ACC to valid latency", n, 10);

    n = 0;
    while (exp0.size() != 0 && n < 3000) begin @(negedge lcd_clk); n++; end
    check("u0 phase1 drained", exp0.size(), 0);
    check("u0 no timeout yet", a0.timeout_err, 0);

    // No data queued: the next conversion must time out.
    n = 0;
    while (a0.wr_n !== 1'b0 && n < 100) begin tick(); n++; end
    check("u0 wr_n before timeout", a0.wr_n, 0);
    n = 0;
    do begin tick(); n++; end while (a0.timeout_err !== 1'b1 && n < 1000);
    check("timeout duration", n, TMO);
    n = 0;
    do begin tick(); n++; end while (a0.wr_n !== 1'b0 && n < 100);
    check("wr_n after timeout", n, SETTLE + 1);

    push0(8'd100);
    n = 0;
    while (exp0.size() != 0 && n < 1000) begin @(negedge lcd_clk); n++; end
    check("u0 recovery drained", exp0.size(), 0);
    check("timeout_err cleared", a0.timeout_err, 0);
    check("u0 sample 100", a0.sample, 100);
    check("u2 phase1 drained", exp2.size(), 0);

    // Two samples into a u2 block, then reset during the third READ.
    dq2.push_back(8'd200);
    dq2.push_back(8'd200);
    dq2.push_back(8'd200);
    n = 0;
    while (dq2.size() != 0 && n < 3000) begin @(negedge lcd_clk); n++; end
    n = 0;
    while (a2.rd_n !== 1'b0 && n < 100) begin tick(); n++; end
    check("u2 reached READ", a2.rd_n, 0);
    #2;
    rst = 1'b0;
    #1;
    check("async reset rd_n", a2.rd_n, 1);
    check("async reset cs_n", a2.cs_n, 1);
    check("async reset sample", a2.sample, 0);
    check("async reset avg", a2.avg, 0);
    check("async reset dig_int", a2.dig_int, 8'h30);
    repeat (3) @(negedge lcd_clk);
    check("u2 valid in reset", a2.valid, 0);

    dq2.push_back(8'd60);
    dq2.push_back(8'd70);
    dq2.push_back(8'd80);
    dq2.push_back(8'd91);
    exp2.push_back(model(301, 4));
    @(negedge lcd_clk);
    rst = 1'b1;
    n = 0;
    while (exp2.size() != 0 && n < 2000) begin @(negedge lcd_clk); n++; end
    check("u2 fresh block drained", exp2.size(), 0);
    check("u2 fresh avg", a2.avg, 75);
    check("u2 last sample", a2.sample, 91);
    repeat (20) @(negedge lcd_clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
